// File: rtl/pipeline_hazard_controller_if.sv
// Hazard-control bundle between the core's pipeline barriers and the hazard controller.
// master: pipeline side (drives hazard sources); slave: controller side.
interface pipeline_hazard_controller_if #(
    parameter int unsigned STALL_CNT_WIDTH = 32
);
    logic [4:0]                 idLHSRegisterIndex;
    logic [4:0]                 idRHSRegisterIndex;
    logic                       idUsesRHS;
    logic                       exMemRead;
    logic [4:0]                 exWriteRegisterIndex;
    logic                       exBranchTaken;
    logic                       exMultiCycleStart;
    logic                       pcDontUpdate;
    logic                       ifIdDontUpdate;
    logic                       idExDontUpdate;
    logic                       ifIdFlush;
    logic                       idExFlush;
    logic                       exMemFlush;
    logic [STALL_CNT_WIDTH-1:0] stallCycles;

    modport master (
        output idLHSRegisterIndex, idRHSRegisterIndex, idUsesRHS, exMemRead,
               exWriteRegisterIndex, exBranchTaken, exMultiCycleStart,
        input  pcDontUpdate, ifIdDontUpdate, idExDontUpdate,
               ifIdFlush, idExFlush, exMemFlush, stallCycles
    );

    modport slave (
        input  idLHSRegisterIndex, idRHSRegisterIndex, idUsesRHS, exMemRead,
               exWriteRegisterIndex, exBranchTaken, exMultiCycleStart,
        output pcDontUpdate, ifIdDontUpdate, idExDontUpdate,
               ifIdFlush, idExFlush, exMemFlush, stallCycles
    );
endinterface

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush generation for load-use, taken branches and multi-cycle EX ops,
// plus a saturating stall-cycle counter.
module pipeline_hazard_controller #(
    parameter int unsigned MULTI_CYCLE_LATENCY = 4,
    parameter int unsigned STALL_CNT_WIDTH     = 32
) (
    input logic                          clk,
    input logic                          rst,
    pipeline_hazard_controller_if.slave  hz
);
    localparam int unsigned CNT_W = (MULTI_CYCLE_LATENCY > 1) ? $clog2(MULTI_CYCLE_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULTI_CYCLE_LATENCY - 1);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        MULTI = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                     state, stateNext;
    logic [CNT_W-1:0]           cnt, cntNext;
    logic [STALL_CNT_WIDTH-1:0] stallCnt;
    logic                       loadUse;
    logic                       pcHold, ifIdHold, idExHold;
    logic                       ifIdClr, idExClr, exMemClr;

    assign loadUse = hz.exMemRead && (hz.exWriteRegisterIndex != 5'd0) &&
                     ((hz.exWriteRegisterIndex == hz.idLHSRegisterIndex) ||
                      (hz.idUsesRHS && (hz.exWriteRegisterIndex == hz.idRHSRegisterIndex)));

    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        pcHold    = 1'b0;
        ifIdHold  = 1'b0;
        idExHold  = 1'b0;
        ifIdClr   = 1'b0;
        idExClr   = 1'b0;
        exMemClr  = 1'b0;
        if (rst) begin
            ifIdClr   = 1'b1;
            idExClr   = 1'b1;
            exMemClr  = 1'b1;
            stateNext = RUN;
            cntNext   = '0;
        end else begin
            unique case (state)
                RUN, DONE: begin
                    stateNext = RUN;
                    if (state == RUN && hz.exMultiCycleStart) begin
                        pcHold    = 1'b1;
                        ifIdHold  = 1'b1;
                        idExHold  = 1'b1;
                        exMemClr  = 1'b1;
                        cntNext   = CNT_LOAD;
                        stateNext = MULTI;
                    end else if (hz.exBranchTaken) begin
                        ifIdClr = 1'b1;
                        idExClr = 1'b1;
                    end else if (loadUse) begin
                        pcHold   = 1'b1;
                        ifIdHold = 1'b1;
                        idExClr  = 1'b1;
                    end
                end
                MULTI: begin
                    pcHold   = 1'b1;
                    ifIdHold = 1'b1;
                    idExHold = 1'b1;
                    exMemClr = 1'b1;
                    // Entry cycle in RUN counts toward the latency, so leave once cnt reaches 1
                    // (LATENCY=1 loads 0 and still spends one cycle here).
                    if (cnt > CNT_W'(1)) begin
                        cntNext = cnt - CNT_W'(1);
                    end else begin
                        cntNext   = '0;
                        stateNext = DONE;
                    end
                end
                default: stateNext = RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RUN;
            cnt      <= '0;
            stallCnt <= '0;
        end else begin
            state <= stateNext;
            cnt   <= cntNext;
            if (pcHold && (stallCnt != '1)) begin
                stallCnt <= stallCnt + STALL_CNT_WIDTH'(1);
            end
        end
    end

    assign hz.pcDontUpdate   = pcHold;
    assign hz.ifIdDontUpdate = ifIdHold;
    assign hz.idExDontUpdate = idExHold;
    assign hz.ifIdFlush      = ifIdClr;
    assign hz.idExFlush      = idExClr;
    assign hz.exMemFlush     = exMemClr;
    assign hz.stallCycles    = stallCnt;
endmodule
